// File: rtl/seq_mac.sv
// Radix-2 shift-add multiply-accumulate unit with START/DONE handshake,
// signed/unsigned operands and a saturating or wrapping accumulator.
module seq_mac #(
    parameter int SIZE  = 4,
    parameter int ACC_W = 2*SIZE+2,
    parameter bit SAT   = 1'b1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [SIZE-1:0]     A,
    input  logic [SIZE-1:0]     B,
    input  logic                SIGNED_MODE,
    input  logic                ACC_EN,
    input  logic                ACC_CLR,
    output logic                READY,
    output logic                DONE,
    output logic [2*SIZE-1:0]   PROD,
    output logic [ACC_W-1:0]    ACC,
    output logic                ACC_OVF
);

    localparam int CW = $clog2(SIZE+1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SIZE-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_r;
    logic [2*SIZE-1:0]    mcand_r;
    logic [SIZE-1:0]      mplier_r;
    logic [2*SIZE-1:0]    partial_r;
    logic [CW-1:0]        cnt_r;
    logic                 neg_r;
    logic                 signed_r;
    logic                 acc_en_r;

    logic [2*SIZE-1:0]    add_term_s;
    logic [2*SIZE-1:0]    prod_s;
    logic [ACC_W-1:0]     prod_ext_s;
    logic [ACC_W:0]       sum_s;
    logic                 ovf_s;
    logic [ACC_W-1:0]     acc_next_s;

    // Magnitude of a SIZE-bit operand; the most negative value maps to 2^(SIZE-1) unsigned.
    function automatic logic [SIZE-1:0] magnitude(input logic [SIZE-1:0] v, input logic is_signed);
        if (is_signed && v[SIZE-1]) begin
            magnitude = ~v + {{(SIZE-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    // Product, its ACC_W extension and the overflow-checked accumulator update.
    always_comb begin
        add_term_s = {(2*SIZE){1'b0}};
        if (mplier_r[0]) begin
            add_term_s = mcand_r;
        end else begin
            add_term_s = {(2*SIZE){1'b0}};
        end

        if (neg_r) begin
            prod_s = ~partial_r + {{(2*SIZE-1){1'b0}}, 1'b1};
        end else begin
            prod_s = partial_r;
        end

        if (signed_r) begin
            prod_ext_s = {{(ACC_W-2*SIZE){prod_s[2*SIZE-1]}}, prod_s};
        end else begin
            prod_ext_s = {{(ACC_W-2*SIZE){1'b0}}, prod_s};
        end

        // One guard bit: the sum overflows when the two top bits disagree.
        sum_s = {ACC[ACC_W-1], ACC} + {prod_ext_s[ACC_W-1], prod_ext_s};
        ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];

        if (ovf_s && SAT) begin
            if (sum_s[ACC_W]) begin
                acc_next_s = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                acc_next_s = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
    end

    // Control FSM, shift-add datapath and all registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r   <= IDLE;
            mcand_r   <= {(2*SIZE){1'b0}};
            mplier_r  <= {SIZE{1'b0}};
            partial_r <= {(2*SIZE){1'b0}};
            cnt_r     <= {CW{1'b0}};
            neg_r     <= 1'b0;
            signed_r  <= 1'b0;
            acc_en_r  <= 1'b0;
            READY     <= 1'b1;
            DONE      <= 1'b0;
            PROD      <= {(2*SIZE){1'b0}};
            ACC       <= {ACC_W{1'b0}};
            ACC_OVF   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    DONE <= 1'b0;
                    if (ACC_CLR) begin
                        ACC     <= {ACC_W{1'b0}};
                        ACC_OVF <= 1'b0;
                    end
                    if (START) begin
                        mcand_r   <= {{SIZE{1'b0}}, magnitude(A, SIGNED_MODE)};
                        mplier_r  <= magnitude(B, SIGNED_MODE);
                        neg_r     <= SIGNED_MODE & (A[SIZE-1] ^ B[SIZE-1]);
                        signed_r  <= SIGNED_MODE;
                        acc_en_r  <= ACC_EN;
                        partial_r <= {(2*SIZE){1'b0}};
                        cnt_r     <= {CW{1'b0}};
                        READY     <= 1'b0;
                        state_r   <= RUN;
                    end
                end
                RUN: begin
                    partial_r <= partial_r + add_term_s;
                    mcand_r   <= {mcand_r[2*SIZE-2:0], 1'b0};
                    mplier_r  <= {1'b0, mplier_r[SIZE-1:1]};
                    cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        state_r <= FIN;
                    end
                end
                FIN: begin
                    PROD    <= prod_s;
                    DONE    <= 1'b1;
                    READY   <= 1'b1;
                    state_r <= IDLE;
                    if (acc_en_r) begin
                        ACC <= acc_next_s;
                        if (ovf_s) begin
                            ACC_OVF <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    READY   <= 1'b1;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mac.sv
// Scoreboard bench for seq_mac: one saturating and one wrapping instance
// share stimulus; a negedge monitor pops expected results on every DONE.
module tb_seq_mac;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, signed_mode, acc_en, acc_clr;
    logic [3:0] a, b;

    logic       ready_s, done_s, ovf_s, ready_w, done_w, ovf_w;
    logic [7:0] prod_s, prod_w;
    logic [9:0] acc_s, acc_w;

    seq_mac #(.SIZE(4), .ACC_W(10), .SAT(1'b1)) dut_sat (
        .CLK(clk), .RST_N(rst_n), .START(start), .A(a), .B(b),
        .SIGNED_MODE(signed_mode), .ACC_EN(acc_en), .ACC_CLR(acc_clr),
        .READY(ready_s), .DONE(done_s), .PROD(prod_s), .ACC(acc_s), .ACC_OVF(ovf_s)
    );

    seq_mac #(.SIZE(4), .ACC_W(10), .SAT(1'b0)) dut_wrap (
        .CLK(clk), .RST_N(rst_n), .START(start), .A(a), .B(b),
        .SIGNED_MODE(signed_mode), .ACC_EN(acc_en), .ACC_CLR(acc_clr),
        .READY(ready_w), .DONE(done_w), .PROD(prod_w), .ACC(acc_w), .ACC_OVF(ovf_w)
    );

    typedef struct {
        logic [7:0] prod;
        logic [9:0] acc_s;
        logic       ovf_s;
        logic [9:0] acc_w;
        logic       ovf_w;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
        logic       en;
        logic       clr;
        logic [7:0] prod;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   m_acc_s = 0;
    int   m_acc_w = 0;
    bit   m_ovf_s = 1'b0;
    bit   m_ovf_w = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Accumulator model: hand-computed product in, expected ACC/ACC_OVF pushed.
    task automatic model_op(input logic sm, input logic en, input logic clr, input logic [7:0] prod);
        int         pv;
        int         sum;
        logic [9:0] low;
        exp_t       e;
        pv = sm ? int'($signed(prod)) : int'(prod);
        if (clr) begin
            m_acc_s = 0; m_acc_w = 0; m_ovf_s = 1'b0; m_ovf_w = 1'b0;
        end
        if (en) begin
            sum = m_acc_s + pv;
            if (sum > 511) begin
                m_acc_s = 511; m_ovf_s = 1'b1;
            end else if (sum < -512) begin
                m_acc_s = -512; m_ovf_s = 1'b1;
            end else begin
                m_acc_s = sum;
            end
            sum = m_acc_w + pv;
            if (sum > 511 || sum < -512) m_ovf_w = 1'b1;
            low = sum[9:0];
            m_acc_w = int'($signed(low));
        end
        e.prod  = prod;
        e.acc_s = m_acc_s[9:0];
        e.ovf_s = m_ovf_s;
        e.acc_w = m_acc_w[9:0];
        e.ovf_w = m_ovf_w;
        sb.push_back(e);
    endtask

    // Issue one op at a negedge with READY high; return at the negedge showing DONE.
    task automatic run_op(input vec_t v);
        int lows;
        lows = 0;
        check("ready_before_start", ready_s, 32'd1);
        a = v.a; b = v.b; signed_mode = v.sm; acc_en = v.en; acc_clr = v.clr;
        start = 1'b1;
        model_op(v.sm, v.en, v.clr, v.prod);
        @(negedge clk);
        start = 1'b0; acc_clr = 1'b0;
        while (ready_s !== 1'b1 && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        check("ready_low_cycles", lows, 32'd5);
        check("done_latency", done_s, 32'd1);
    endtask

    // Monitor: every DONE pops one expected entry and compares both instances.
    always @(negedge clk) begin
        if (done_s === 1'b1 || done_w === 1'b1) begin
            check("done_lockstep", done_w, done_s);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done expected=no_done");
            end else begin
                mon_e = sb.pop_front();
                check("prod_sat", prod_s, mon_e.prod);
                check("prod_wrap", prod_w, mon_e.prod);
                check("acc_sat", acc_s, mon_e.acc_s);
                check("ovf_sat", ovf_s, mon_e.ovf_s);
                check("acc_wrap", acc_w, mon_e.acc_w);
                check("ovf_wrap", ovf_w, mon_e.ovf_w);
            end
        end
    end

    vec_t prod_vecs[6] = '{
        '{4'd15,    4'd15,    1'b0, 1'b0, 1'b0, 8'hE1},
        '{4'b1101,  4'd5,     1'b1, 1'b0, 1'b0, 8'hF1},
        '{4'b1000,  4'b1000,  1'b1, 1'b0, 1'b0, 8'h40},
        '{4'd0,     4'b1000,  1'b1, 1'b0, 1'b0, 8'h00},
        '{4'd5,     4'd5,     1'b0, 1'b0, 1'b0, 8'h19},
        '{4'b1011,  4'b1011,  1'b1, 1'b0, 1'b0, 8'h19}
    };

    initial begin
        vec_t v;
        rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
        signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready_s, 32'd1);
        check("rst_done", done_s, 32'd0);
        check("rst_prod", prod_s, 32'd0);
        check("rst_acc", acc_s, 32'd0);
        check("rst_ovf", ovf_s, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (prod_vecs[i]) run_op(prod_vecs[i]);

        // 7x7 signed accumulation, clearing with the first start.
        for (int i = 0; i < 11; i++) begin
            v = '{4'd7, 4'd7, 1'b1, 1'b1, (i == 0), 8'h31};
            run_op(v);
            if (i == 9) begin
                check("acc10_sat", acc_s, 32'd490);
                check("ovf10_sat", ovf_s, 32'd0);
                check("acc10_wrap", acc_w, 32'd490);
            end
        end
        check("acc11_sat", acc_s, 32'h1FF);
        check("ovf11_sat", ovf_s, 32'd1);
        check("acc11_wrap", acc_w, 32'h21B);
        check("ovf11_wrap", ovf_w, 32'd1);

        acc_clr = 1'b1;
        m_acc_s = 0; m_acc_w = 0; m_ovf_s = 1'b0; m_ovf_w = 1'b0;
        @(negedge clk);
        acc_clr = 1'b0;
        check("clr_acc_sat", acc_s, 32'd0);
        check("clr_ovf_sat", ovf_s, 32'd0);
        check("clr_acc_wrap", acc_w, 32'd0);
        check("clr_ovf_wrap", ovf_w, 32'd0);

        // Negative signed product, then an unsigned one that must zero-extend.
        v = '{4'b1101, 4'd5, 1'b1, 1'b1, 1'b0, 8'hF1};
        run_op(v);
        check("acc_neg", acc_s, 32'h3F1);
        v = '{4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 8'hE1};
        run_op(v);
        check("acc_zext", acc_s, 32'd210);

        // START held high: accepts only every SIZE+2 cycles.
        a = 4'd2; b = 4'd3; signed_mode = 1'b0; acc_en = 1'b0;
        for (int i = 0; i < 3; i++) model_op(1'b0, 1'b0, 1'b0, 8'h06);
        start = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            check("held_ready", ready_s, ((j % 6) == 0) ? 32'd1 : 32'd0);
            check("held_done", done_s, ((j % 6) == 0) ? 32'd1 : 32'd0);
            if (j == 13) start = 1'b0;
        end

        // Reset during the second RUN cycle aborts the op without DONE.
        a = 4'd7; b = 4'd7; signed_mode = 1'b1; acc_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ready", ready_s, 32'd1);
        check("abort_prod", prod_s, 32'd0);
        check("abort_acc", acc_s, 32'd0);
        check("abort_ovf", ovf_s, 32'd0);
        check("abort_done", done_s, 32'd0);
        rst_n = 1'b1;
        m_acc_s = 0; m_acc_w = 0; m_ovf_s = 1'b0; m_ovf_w = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("no_done_after_abort", done_s, 32'd0);
        end

        v = '{4'd3, 4'd3, 1'b0, 1'b1, 1'b0, 8'h09};
        run_op(v);
        check("acc_after_reset", acc_s, 32'd9);

        @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
